// File: rtl/core_run_controller.sv
// ============================================================================
//  Module      : core_run_controller
//  Description : Run/halt/single-step sequencer for the JZJCoreF core.
//                Synchronizes and debounces the raw devboard buttons, then
//                drives a one-cycle core clock enable (full-rate, slow, or
//                single step), a timed core reset, and clean button levels.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module core_run_controller #(
  parameter int DEBOUNCE_CYCLES   = 250000,
  parameter int SLOW_DIV_LOG2     = 19,
  parameter int RESET_HOLD_CYCLES = 16
) (
  input  logic        clock,
  input  logic        notReset,
  input  logic [3:0]  button,
  output logic        coreClockEnable,
  output logic        coreReset,
  output logic [3:0]  buttonClean,
  output logic [2:0]  runState,
  output logic [31:0] enableCount
);

  localparam int DB_W   = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int HOLD_W = $clog2(RESET_HOLD_CYCLES + 1);

  localparam logic [DB_W-1:0]          DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0]        HOLD_LAST = HOLD_W'(RESET_HOLD_CYCLES - 1);
  localparam logic [SLOW_DIV_LOG2-1:0] DIV_LAST  = '1;

  localparam logic [2:0] ST_RESETTING = 3'd0;
  localparam logic [2:0] ST_HALTED    = 3'd1;
  localparam logic [2:0] ST_RUN_FAST  = 3'd2;
  localparam logic [2:0] ST_RUN_SLOW  = 3'd3;
  localparam logic [2:0] ST_STEP      = 3'd4;

  // Button front end
  logic [3:0]      sync1_q, sync1_d;
  logic [3:0]      sync2_q, sync2_d;
  logic [3:0]      deb_q, deb_d;
  logic [DB_W-1:0] db_cnt_q [4];
  logic [DB_W-1:0] db_cnt_d [4];
  // Edge detection only for the three momentary buttons: {reset, step, run}
  logic [2:0]      deb_dly_q, deb_dly_d;
  logic [2:0]      pulse_q, pulse_d;

  // Sequencer
  logic [2:0]               state_q, state_d;
  logic [HOLD_W-1:0]        hold_q, hold_d;
  logic [SLOW_DIV_LOG2-1:0] div_q, div_d;
  logic                     enable_q, enable_d;
  logic                     reset_q, reset_d;
  logic [31:0]              count_q, count_d;
  logic                     slow_tick;

  logic run_pulse, step_pulse, reset_pulse, mode_slow;

  assign run_pulse   = pulse_q[0];
  assign step_pulse  = pulse_q[1];
  assign reset_pulse = pulse_q[2];
  assign mode_slow   = deb_q[2];

  // Two-flop synchronizer, per-button debounce and registered rising-edge pulses
  always_comb begin
    sync1_d   = button;
    sync2_d   = sync1_q;
    deb_d     = deb_q;
    for (int i = 0; i < 4; i++) begin
      db_cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) begin
          deb_d[i] = ~deb_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
        end
      end
    end
    deb_dly_d = {deb_q[3], deb_q[1], deb_q[0]};
    pulse_d   = {deb_q[3], deb_q[1], deb_q[0]} & ~deb_dly_q;
  end

  // Next-state logic; enable and reset are decoded from the next state so they leave a flop
  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    div_d     = '0;
    slow_tick = 1'b0;
    if (reset_pulse) begin
      state_d = ST_RESETTING;
      hold_d  = '0;
    end else begin
      case (state_q)
        ST_RESETTING: begin
          if (hold_q == HOLD_LAST) begin
            state_d = ST_HALTED;
            hold_d  = '0;
          end else begin
            hold_d = hold_q + HOLD_W'(1);
          end
        end
        ST_HALTED: begin
          if (run_pulse) begin
            state_d = mode_slow ? ST_RUN_SLOW : ST_RUN_FAST;
          end else if (step_pulse) begin
            state_d = ST_STEP;
          end
        end
        ST_STEP: begin
          state_d = ST_HALTED;
        end
        ST_RUN_FAST: begin
          if (run_pulse) begin
            state_d = ST_HALTED;
          end else if (mode_slow) begin
            state_d = ST_RUN_SLOW;
          end
        end
        ST_RUN_SLOW: begin
          if (run_pulse) begin
            state_d = ST_HALTED;
          end else if (!mode_slow) begin
            state_d = ST_RUN_FAST;
          end else begin
            // Divider runs only while staying in slow mode; any entry starts it at zero
            div_d     = div_q + SLOW_DIV_LOG2'(1);
            slow_tick = (div_q == DIV_LAST);
          end
        end
        default: begin
          state_d = ST_RESETTING;
          hold_d  = '0;
        end
      endcase
    end
    enable_d = (state_d == ST_RUN_FAST) || (state_d == ST_STEP) || slow_tick;
    reset_d  = (state_d == ST_RESETTING);
    count_d  = reset_pulse ? 32'd0 : count_q + 32'(enable_q);
  end

  // State registers; reset puts the core into its hold-in-reset phase
  always_ff @(posedge clock or negedge notReset) begin
    if (!notReset) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      deb_q     <= '0;
      deb_dly_q <= '0;
      pulse_q   <= '0;
      for (int i = 0; i < 4; i++) begin
        db_cnt_q[i] <= '0;
      end
      state_q   <= ST_RESETTING;
      hold_q    <= '0;
      div_q     <= '0;
      enable_q  <= 1'b0;
      reset_q   <= 1'b1;
      count_q   <= '0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      deb_q     <= deb_d;
      deb_dly_q <= deb_dly_d;
      pulse_q   <= pulse_d;
      for (int i = 0; i < 4; i++) begin
        db_cnt_q[i] <= db_cnt_d[i];
      end
      state_q   <= state_d;
      hold_q    <= hold_d;
      div_q     <= div_d;
      enable_q  <= enable_d;
      reset_q   <= reset_d;
      count_q   <= count_d;
    end
  end

  assign coreClockEnable = enable_q;
  assign coreReset       = reset_q;
  assign buttonClean     = deb_q;
  assign runState        = state_q;
  assign enableCount     = count_q;

endmodule

`default_nettype wire

// File: tb/tb_core_run_controller.sv
// ============================================================================
//  Module      : tb_core_run_controller
//  Description : Self-checking bench for core_run_controller. A behavioural
//                model (sliding-window debounce, time-in-state sequencing)
//                runs beside the DUT; scenario tasks add absolute checks.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_core_run_controller;

  localparam int DB   = 4;
  localparam int SDL  = 3;
  localparam int HOLD = 4;
  localparam int PERIOD = 1 << SDL;

  localparam logic [2:0] S_RST  = 3'd0;
  localparam logic [2:0] S_HALT = 3'd1;
  localparam logic [2:0] S_FAST = 3'd2;
  localparam logic [2:0] S_SLOW = 3'd3;
  localparam logic [2:0] S_STEP = 3'd4;

  logic        clk;
  logic        rst_n;
  logic [3:0]  button;
  logic        coreClockEnable;
  logic        coreReset;
  logic [3:0]  buttonClean;
  logic [2:0]  runState;
  logic [31:0] enableCount;

  int checks;
  int errors;

  core_run_controller #(
    .DEBOUNCE_CYCLES   (DB),
    .SLOW_DIV_LOG2     (SDL),
    .RESET_HOLD_CYCLES (HOLD)
  ) dut (
    .clock           (clk),
    .notReset        (rst_n),
    .button          (button),
    .coreClockEnable (coreClockEnable),
    .coreReset       (coreReset),
    .buttonClean     (buttonClean),
    .runState        (runState),
    .enableCount     (enableCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural reference model ----------------
  typedef struct packed {
    logic [3:0]         s1;
    logic [3:0]         s2;
    logic [DB-1:0][3:0] hist;     // last DB synchronized samples, [0] newest
    logic [3:0]         deb;
    logic [3:0]         deb_prev;
    logic [3:0]         deb_prev2;
    logic [2:0]         state;
    logic [31:0]        cyc;      // edges spent in the current state
    logic               en;
    logic               crst;
    logic [31:0]        cnt;
  } model_t;

  function automatic model_t model_reset();
    model_t r;
    r = '0;
    r.state = S_RST;
    r.crst  = 1'b1;
    return r;
  endfunction

  function automatic model_t model_step(input model_t m, input logic [3:0] raw);
    model_t     n;
    logic [3:0] press;
    logic       mode;
    logic       all_diff;
    n = m;
    n.s1   = raw;
    n.s2   = m.s1;
    n.hist = {m.hist[DB-2:0], m.s2};
    // Level flips once DB consecutive synchronized samples disagree with it
    for (int b = 0; b < 4; b++) begin
      all_diff = 1'b1;
      for (int i = 0; i < DB; i++) begin
        if (n.hist[i][b] == m.deb[b]) all_diff = 1'b0;
      end
      if (all_diff) n.deb[b] = ~m.deb[b];
    end
    n.deb_prev  = m.deb;
    n.deb_prev2 = m.deb_prev;
    // A press is acted on two edges after its debounced level rises
    press = m.deb_prev & ~m.deb_prev2;
    mode  = m.deb[2];
    n.cyc = m.cyc + 1;
    if (press[3]) begin
      n.state = S_RST; n.cyc = 0;
    end else begin
      case (m.state)
        S_RST:  if (m.cyc + 1 >= HOLD) begin n.state = S_HALT; n.cyc = 0; end
        S_HALT: if (press[0]) begin n.state = mode ? S_SLOW : S_FAST; n.cyc = 0; end
                else if (press[1]) begin n.state = S_STEP; n.cyc = 0; end
        S_STEP: begin n.state = S_HALT; n.cyc = 0; end
        S_FAST: if (press[0]) begin n.state = S_HALT; n.cyc = 0; end
                else if (mode) begin n.state = S_SLOW; n.cyc = 0; end
        S_SLOW: if (press[0]) begin n.state = S_HALT; n.cyc = 0; end
                else if (!mode) begin n.state = S_FAST; n.cyc = 0; end
        default: begin n.state = S_RST; n.cyc = 0; end
      endcase
    end
    n.en   = (n.state == S_FAST) || (n.state == S_STEP) ||
             ((n.state == S_SLOW) && (n.cyc != 0) && (n.cyc % PERIOD == 0));
    n.crst = (n.state == S_RST);
    n.cnt  = press[3] ? 32'd0 : m.cnt + {31'd0, m.en};
    return n;
  endfunction

  model_t m;

  // Model advances on the same edges as the DUT and clears with the async reset
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= model_reset();
    else        m <= model_step(m, button);
  end

  logic [40:0] obs, exp_v;
  assign obs   = {runState, coreReset, coreClockEnable, buttonClean, enableCount};
  assign exp_v = {m.state, m.crst, m.en, m.deb, m.cnt};

  localparam logic [40:0] RESET_OUT = {S_RST, 1'b1, 1'b0, 4'd0, 32'd0};

  // ---------------- scenarios ----------------
  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (obs !== RESET_OUT) begin
      errors++; $display("FAIL reset_state got %h expected %h", obs, RESET_OUT);
    end
    rst_n = 1'b1;
    for (int k = 1; k <= HOLD; k++) begin
      @(negedge clk);
      checks++;
      if (obs !== exp_v) begin
        errors++; $display("FAIL reset_model k=%0d got %h expected %h", k, obs, exp_v);
      end
      checks++;
      if (k < HOLD && {runState, coreReset} !== {S_RST, 1'b1}) begin
        errors++; $display("FAIL reset_hold k=%0d got %h expected %h", k, {runState, coreReset}, {S_RST, 1'b1});
      end else if (k == HOLD && obs !== {S_HALT, 1'b0, 1'b0, 4'd0, 32'd0}) begin
        errors++; $display("FAIL reset_done got %h expected %h", obs, {S_HALT, 1'b0, 1'b0, 4'd0, 32'd0});
      end
    end
  endtask

  task automatic test_step();
    button = 4'b0010;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      checks++;
      if (obs !== exp_v) begin
        errors++; $display("FAIL step_model k=%0d got %h expected %h", k, obs, exp_v);
      end
      if (k == 7) begin
        checks++;
        if (runState !== S_HALT) begin
          errors++; $display("FAIL step_early got %0d expected %0d", runState, S_HALT);
        end
      end
      if (k == 8) begin
        checks++;
        if ({runState, coreClockEnable} !== {S_STEP, 1'b1}) begin
          errors++; $display("FAIL step_enter got %h expected %h", {runState, coreClockEnable}, {S_STEP, 1'b1});
        end
      end
      if (k == 9 || k == 20) begin
        checks++;
        if ({runState, coreClockEnable, enableCount} !== {S_HALT, 1'b0, 32'd1}) begin
          errors++; $display("FAIL step_done k=%0d got %h expected %h", k, {runState, coreClockEnable, enableCount}, {S_HALT, 1'b0, 32'd1});
        end
      end
      if (k == 20) button = 4'b0000;
    end
  endtask

  task automatic test_glitch_and_fast();
    button = 4'b0001;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 3) button = 4'b0000;
      checks++;
      if (obs !== exp_v || buttonClean[0] !== 1'b0 || runState !== S_HALT) begin
        errors++; $display("FAIL glitch k=%0d got %h expected %h", k, obs, exp_v);
      end
    end
    // Press, hold, release, then press again to halt
    for (int p = 0; p < 2; p++) begin
      button = 4'b0001;
      for (int k = 1; k <= 20; k++) begin
        @(negedge clk);
        if (k == 10) button = 4'b0000;
        checks++;
        if (obs !== exp_v) begin
          errors++; $display("FAIL fast_model p=%0d k=%0d got %h expected %h", p, k, obs, exp_v);
        end
        if (k >= 8) begin
          checks++;
          if (p == 0 && {runState, coreClockEnable} !== {S_FAST, 1'b1}) begin
            errors++; $display("FAIL fast_run k=%0d got %h expected %h", k, {runState, coreClockEnable}, {S_FAST, 1'b1});
          end else if (p == 1 && {runState, coreClockEnable} !== {S_HALT, 1'b0}) begin
            errors++; $display("FAIL fast_halt k=%0d got %h expected %h", k, {runState, coreClockEnable}, {S_HALT, 1'b0});
          end
        end
      end
    end
  endtask

  task automatic test_slow();
    logic [31:0] base;
    base = 32'd0;
    button = 4'b0100;
    repeat (10) begin
      @(negedge clk);
      checks++;
      if (obs !== exp_v) begin
        errors++; $display("FAIL slow_mode got %h expected %h", obs, exp_v);
      end
    end
    button = 4'b0101;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 20) button = 4'b0100;
      checks++;
      if (obs !== exp_v) begin
        errors++; $display("FAIL slow_model k=%0d got %h expected %h", k, obs, exp_v);
      end
      if (k == 8) begin
        base = enableCount;
        checks++;
        if ({runState, coreClockEnable} !== {S_SLOW, 1'b0}) begin
          errors++; $display("FAIL slow_enter got %h expected %h", {runState, coreClockEnable}, {S_SLOW, 1'b0});
        end
      end
      if (k == 15 || k == 16 || k == 24) begin
        checks++;
        if (coreClockEnable !== (k == 16 || k == 24)) begin
          errors++; $display("FAIL slow_tick k=%0d got %b expected %b", k, coreClockEnable, (k == 16 || k == 24));
        end
      end
      if (k == 33) begin
        checks++;
        if (enableCount !== base + 32'd3) begin
          errors++; $display("FAIL slow_count got %0d expected %0d", enableCount, base + 32'd3);
        end
      end
    end
  endtask

  task automatic test_simultaneous_reset();
    button = 4'b0000;   // mode back to fast while running
    repeat (12) begin
      @(negedge clk);
      checks++;
      if (obs !== exp_v) begin
        errors++; $display("FAIL switch_model got %h expected %h", obs, exp_v);
      end
    end
    checks++;
    if (runState !== S_FAST) begin
      errors++; $display("FAIL switch_fast got %0d expected %0d", runState, S_FAST);
    end
    button = 4'b1011;
    for (int k = 1; k <= 22; k++) begin
      @(negedge clk);
      if (k == 12) button = 4'b0000;
      checks++;
      if (obs !== exp_v) begin
        errors++; $display("FAIL multi_model k=%0d got %h expected %h", k, obs, exp_v);
      end
      if (k >= 8 && k <= 11) begin
        checks++;
        if ({runState, coreReset, coreClockEnable, enableCount} !== {S_RST, 1'b1, 1'b0, 32'd0}) begin
          errors++; $display("FAIL multi_reset k=%0d got %h expected %h", k, {runState, coreReset, coreClockEnable, enableCount}, {S_RST, 1'b1, 1'b0, 32'd0});
        end
      end
      if (k == 12) begin
        checks++;
        if ({runState, coreReset} !== {S_HALT, 1'b0}) begin
          errors++; $display("FAIL multi_done got %h expected %h", {runState, coreReset}, {S_HALT, 1'b0});
        end
      end
    end
  endtask

  task automatic test_async_reset();
    button = 4'b0001;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 10) button = 4'b0000;
      checks++;
      if (obs !== exp_v) begin
        errors++; $display("FAIL async_pre k=%0d got %h expected %h", k, obs, exp_v);
      end
    end
    checks++;
    if ({runState, coreClockEnable} !== {S_FAST, 1'b1}) begin
      errors++; $display("FAIL async_running got %h expected %h", {runState, coreClockEnable}, {S_FAST, 1'b1});
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== RESET_OUT) begin
      errors++; $display("FAIL async_clear got %h expected %h", obs, RESET_OUT);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      checks++;
      if (obs !== exp_v) begin
        errors++; $display("FAIL async_post k=%0d got %h expected %h", k, obs, exp_v);
      end
      checks++;
      if (k < HOLD && coreReset !== 1'b1) begin
        errors++; $display("FAIL async_hold k=%0d got %b expected 1", k, coreReset);
      end else if (k >= HOLD && {runState, coreReset, enableCount} !== {S_HALT, 1'b0, 32'd0}) begin
        errors++; $display("FAIL async_done k=%0d got %h expected %h", k, {runState, coreReset, enableCount}, {S_HALT, 1'b0, 32'd0});
      end
    end
  endtask

  task automatic test_random();
    int hold;
    for (int seg = 0; seg < 300; seg++) begin
      button[0] = ($urandom_range(0, 2) == 0);
      button[1] = ($urandom_range(0, 2) == 0);
      button[2] = ($urandom_range(0, 1) == 0);
      button[3] = ($urandom_range(0, 9) == 0);
      hold = $urandom_range(1, 12);
      repeat (hold) begin
        @(negedge clk);
        checks++;
        if (obs !== exp_v) begin
          errors++; $display("FAIL random seg=%0d got %h expected %h", seg, obs, exp_v);
        end
      end
    end
    button = 4'b0000;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    button = 4'b0000;
    test_reset();
    test_step();
    test_glitch_and_fast();
    test_slow();
    test_simultaneous_reset();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
